// File: rtl/data_path_pkg.sv
// Shared types for the single-bus datapath: word width, ALU op codes, bus-source codes.
// Latency: n/a (types and pure functions only); backpressure: none.
package data_path_pkg;

    localparam int WORD = 32;

    // Order matches the op-select port order, so the lowest code has the highest priority.
    typedef enum logic [3:0] {
        OP_ADD, OP_SUB, OP_SHR, OP_SHRA, OP_SHL, OP_ROR, OP_ROL,
        OP_AND, OP_OR, OP_MUL, OP_DIV, OP_NEG, OP_NOT, OP_INC
    } alu_op_t;

    typedef logic [4:0] bus_src_t;

    localparam bus_src_t SRC_HI   = 5'd16;
    localparam bus_src_t SRC_LO   = 5'd17;
    localparam bus_src_t SRC_ZHI  = 5'd18;
    localparam bus_src_t SRC_ZLO  = 5'd19;
    localparam bus_src_t SRC_PC   = 5'd20;
    localparam bus_src_t SRC_MDR  = 5'd21;
    localparam bus_src_t SRC_NONE = 5'd22;

    function automatic alu_op_t decode_op(input logic [12:0] sel);
        alu_op_t op = OP_INC;
        for (int i = 12; i >= 0; i--) begin
            if (sel[i]) op = alu_op_t'(4'(i));
        end
        return op;
    endfunction

    function automatic bus_src_t encode_src(input logic [21:0] sel);
        bus_src_t src = SRC_NONE;
        for (int i = 21; i >= 0; i--) begin
            if (sel[i]) src = bus_src_t'(5'(i));
        end
        return src;
    endfunction

endpackage

// File: rtl/data_path_alu.sv
// Combinational 32-bit ALU with 64-bit result (shifter, multiplier, divider inside).
// Latency: 0 cycles; backpressure: none.
module alu
    import data_path_pkg::*;
(
    input  logic [WORD-1:0]   a,
    input  logic [WORD-1:0]   b,
    input  alu_op_t           op,
    output logic [2*WORD-1:0] result
);

    logic [4:0]         sh;
    logic [63:0]        rot_r;
    logic [63:0]        rot_l;
    logic signed [63:0] prod;
    logic signed [31:0] quo;
    logic signed [31:0] rem;

    always_comb begin
        sh     = b[4:0];
        rot_r  = {a, a} >> sh;
        rot_l  = {a, a} << sh;
        prod   = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
        quo    = $signed(a) / $signed(b);
        rem    = $signed(a) % $signed(b);
        result = '0;
        case (op)
            OP_ADD:  result[31:0] = a + b;
            OP_SUB:  result[31:0] = a - b;
            OP_SHR:  result[31:0] = a >> sh;
            OP_SHRA: result[31:0] = $signed(a) >>> sh;
            OP_SHL:  result[31:0] = a << sh;
            OP_ROR:  result[31:0] = rot_r[31:0];
            OP_ROL:  result[31:0] = rot_l[63:32];
            OP_AND:  result[31:0] = a & b;
            OP_OR:   result[31:0] = a | b;
            OP_MUL:  result       = prod;
            // Divide-by-zero returns all-ones quotient and passes the dividend through as remainder.
            OP_DIV:  result       = (b == '0) ? {a, 32'hFFFF_FFFF} : {rem, quo};
            OP_NEG:  result[31:0] = -b;
            OP_NOT:  result[31:0] = ~b;
            default: result[31:0] = b + 32'd1;
        endcase
    end

endmodule

// File: rtl/data_path.sv
// Single-bus datapath: register file, special registers, priority bus mux, MDR mux, ALU into Z.
// Latency: bus/ALU combinational, registers load on the next Clock edge; backpressure: none.
module data_path
    import data_path_pkg::*;
(
    input  logic            Clock,
    input  logic            Clear,
    input  logic            HIin, HIout, LOin, LOout,
    input  logic            PCin, PCout,
    input  logic            IRin,
    input  logic            Zin,
    input  logic            Zhighout, Zlowout,
    input  logic            Yin,
    input  logic            MARin,
    input  logic            MDRin, MDRout,
    input  logic            Read,
    input  logic [WORD-1:0] Mdatain,
    input  logic            R0out, R1out, R2out, R3out, R4out, R5out, R6out, R7out,
    input  logic            R8out, R9out, R10out, R11out, R12out, R13out, R14out, R15out,
    input  logic            R0in, R1in, R2in, R3in, R4in, R5in, R6in, R7in,
    input  logic            R8in, R9in, R10in, R11in, R12in, R13in, R14in, R15in,
    input  logic            ADD, SUB, SHR, SHRA, SHL, ROR, ROL, AND, OR, MUL, DIV, NEG, NOT,
    output logic [WORD-1:0] BusMuxOut
);

    logic [WORD-1:0]   gpr [16];
    logic [WORD-1:0]   pc, ir, mar, mdr, y, hi, lo;
    logic [2*WORD-1:0] z;
    logic [2*WORD-1:0] alu_res;
    logic [WORD-1:0]   bus;
    logic [WORD-1:0]   mdr_d;
    logic [15:0]       r_out, r_in;
    bus_src_t          src;
    alu_op_t           op;

    assign r_out = {R15out, R14out, R13out, R12out, R11out, R10out, R9out, R8out,
                    R7out, R6out, R5out, R4out, R3out, R2out, R1out, R0out};
    assign r_in  = {R15in, R14in, R13in, R12in, R11in, R10in, R9in, R8in,
                    R7in, R6in, R5in, R4in, R3in, R2in, R1in, R0in};

    assign src   = encode_src({MDRout, PCout, Zlowout, Zhighout, LOout, HIout, r_out});
    assign op    = decode_op({NOT, NEG, DIV, MUL, OR, AND, ROL, ROR, SHL, SHRA, SHR, SUB, ADD});

    always_comb begin
        bus = '0;
        case (src)
            SRC_HI:  bus = hi;
            SRC_LO:  bus = lo;
            SRC_ZHI: bus = z[63:32];
            SRC_ZLO: bus = z[31:0];
            SRC_PC:  bus = pc;
            SRC_MDR: bus = mdr;
            default: if (src < SRC_HI) bus = gpr[src[3:0]];
        endcase
    end

    assign BusMuxOut = bus;
    assign mdr_d     = Read ? Mdatain : bus;

    alu u_alu (
        .a      (y),
        .b      (bus),
        .op     (op),
        .result (alu_res)
    );

    always_ff @(posedge Clock or negedge Clear) begin
        if (!Clear) begin
            for (int i = 0; i < 16; i++) gpr[i] <= '0;
            pc  <= '0;
            ir  <= '0;
            mar <= '0;
            mdr <= '0;
            y   <= '0;
            z   <= '0;
            hi  <= '0;
            lo  <= '0;
        end else begin
            for (int i = 0; i < 16; i++) begin
                if (r_in[i]) gpr[i] <= bus;
            end
            if (PCin)  pc  <= bus;
            if (IRin)  ir  <= bus;
            if (MARin) mar <= bus;
            if (MDRin) mdr <= mdr_d;
            if (Yin)   y   <= bus;
            if (Zin)   z   <= alu_res;
            if (HIin)  hi  <= bus;
            if (LOin)  lo  <= bus;
        end
    end

endmodule

// File: tb/tb_data_path.sv
// Self-checking bench for data_path: directed sequences, an ALU vector table and a randomized model check.
module tb_data_path;

    logic        Clock = 1'b0;
    logic        Clear;
    logic        HIin, HIout, LOin, LOout, PCin, PCout, IRin, Zin, Zhighout, Zlowout;
    logic        Yin, MARin, MDRin, MDRout, Read;
    logic [31:0] Mdatain;
    logic [15:0] r_out, r_in;
    logic [12:0] ops;
    logic [31:0] BusMuxOut;

    int total = 0;
    int bad   = 0;

    always #5 Clock = ~Clock;

    data_path dut (
        .Clock(Clock), .Clear(Clear),
        .HIin(HIin), .HIout(HIout), .LOin(LOin), .LOout(LOout),
        .PCin(PCin), .PCout(PCout), .IRin(IRin), .Zin(Zin),
        .Zhighout(Zhighout), .Zlowout(Zlowout), .Yin(Yin), .MARin(MARin),
        .MDRin(MDRin), .MDRout(MDRout), .Read(Read), .Mdatain(Mdatain),
        .R0out(r_out[0]), .R1out(r_out[1]), .R2out(r_out[2]), .R3out(r_out[3]),
        .R4out(r_out[4]), .R5out(r_out[5]), .R6out(r_out[6]), .R7out(r_out[7]),
        .R8out(r_out[8]), .R9out(r_out[9]), .R10out(r_out[10]), .R11out(r_out[11]),
        .R12out(r_out[12]), .R13out(r_out[13]), .R14out(r_out[14]), .R15out(r_out[15]),
        .R0in(r_in[0]), .R1in(r_in[1]), .R2in(r_in[2]), .R3in(r_in[3]),
        .R4in(r_in[4]), .R5in(r_in[5]), .R6in(r_in[6]), .R7in(r_in[7]),
        .R8in(r_in[8]), .R9in(r_in[9]), .R10in(r_in[10]), .R11in(r_in[11]),
        .R12in(r_in[12]), .R13in(r_in[13]), .R14in(r_in[14]), .R15in(r_in[15]),
        .ADD(ops[0]), .SUB(ops[1]), .SHR(ops[2]), .SHRA(ops[3]), .SHL(ops[4]),
        .ROR(ops[5]), .ROL(ops[6]), .AND(ops[7]), .OR(ops[8]), .MUL(ops[9]),
        .DIV(ops[10]), .NEG(ops[11]), .NOT(ops[12]),
        .BusMuxOut(BusMuxOut)
    );

    typedef struct {
        string       name;
        logic [12:0] sel;
        logic [31:0] a;
        logic [31:0] b;
        logic [63:0] exp;
    } vec_t;

    vec_t tbl[$];

    function automatic logic [12:0] m(input int k);
        logic [12:0] one = 13'd1;
        return one << k;
    endfunction

    // Reference ALU: first selected op in port order, otherwise the increment path.
    function automatic logic [63:0] ref_alu(input logic [12:0] sel, input logic [31:0] a, input logic [31:0] b);
        int                 k  = 13;
        int                 s  = int'(b[4:0]);
        logic signed [31:0] sa = a;
        logic signed [31:0] sb = b;
        logic [31:0]        w;
        longint             p;
        for (int i = 12; i >= 0; i--) if (sel[i]) k = i;
        case (k)
            0:  w = a + b;
            1:  w = a - b;
            2:  w = a >> s;
            3:  w = sa >>> s;
            4:  w = a << s;
            5:  w = (a >> s) | (a << (32 - s));
            6:  w = (a << s) | (a >> (32 - s));
            7:  w = a & b;
            8:  w = a | b;
            9:  begin p = longint'(sa) * longint'(sb); return p; end
            10: begin
                if (b == 0) return {a, 32'hFFFF_FFFF};
                return {32'(sa % sb), 32'(sa / sb)};
            end
            11: w = 32'd0 - b;
            12: w = ~b;
            default: w = b + 32'd1;
        endcase
        return {32'h0, w};
    endfunction

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h expected=%h", name, got, exp);
        end
    endtask

    task automatic idle();
        {HIin, HIout, LOin, LOout, PCin, PCout, IRin, Zin, Zhighout, Zlowout} = '0;
        {Yin, MARin, MDRin, MDRout, Read} = '0;
        Mdatain = '0;
        r_out = '0;
        r_in = '0;
        ops = '0;
    endtask

    task automatic tick();
        @(posedge Clock);
        #1;
        idle();
    endtask

    task automatic load_mdr(input logic [31:0] v);
        Mdatain = v; Read = 1'b1; MDRin = 1'b1;
        tick();
    endtask

    task automatic check_reg(input string name, input int i, input logic [31:0] exp);
        r_out[i] = 1'b1; #1;
        check(name, {32'h0, BusMuxOut}, {32'h0, exp});
        r_out[i] = 1'b0;
    endtask

    task automatic read_z(output logic [63:0] zv);
        Zhighout = 1'b1; #1; zv[63:32] = BusMuxOut; Zhighout = 1'b0;
        Zlowout  = 1'b1; #1; zv[31:0]  = BusMuxOut; Zlowout  = 1'b0;
    endtask

    task automatic alu_run(input logic [12:0] sel, input logic [31:0] a, input logic [31:0] b,
                           output logic [63:0] zv);
        load_mdr(a);
        MDRout = 1'b1; Yin = 1'b1;
        tick();
        load_mdr(b);
        MDRout = 1'b1; ops = sel; Zin = 1'b1;
        tick();
        read_z(zv);
    endtask

    initial begin
        logic [63:0] zv;
        logic [12:0] sel;
        logic [31:0] a, b;

        idle();
        Clear = 1'b0;
        #3;
        for (int i = 0; i < 16; i += 5) check_reg($sformatf("reset_r%0d", i), i, 32'h0);
        PCout = 1'b1; #1; check("reset_pc", {32'h0, BusMuxOut}, 64'h0); PCout = 1'b0;
        read_z(zv); check("reset_z", zv, 64'h0);
        #1; check("bus_idle", {32'h0, BusMuxOut}, 64'h0);
        @(negedge Clock);
        Clear = 1'b1;
        tick();

        load_mdr(32'h12); MDRout = 1'b1; r_in[2] = 1'b1; tick();
        load_mdr(32'h14); MDRout = 1'b1; r_in[3] = 1'b1; tick();
        load_mdr(32'h18); MDRout = 1'b1; r_in[1] = 1'b1; tick();
        check_reg("load_r2", 2, 32'h12);
        check_reg("load_r3", 3, 32'h14);
        check_reg("load_r1", 1, 32'h18);

        PCout = 1'b1; MARin = 1'b1; Zin = 1'b1; tick();
        check("fetch_mar", {32'h0, dut.mar}, 64'h0);
        read_z(zv); check("fetch_z", zv, 64'h1);
        Zlowout = 1'b1; PCin = 1'b1; Read = 1'b1; MDRin = 1'b1; Mdatain = 32'h54C6_0000; tick();
        PCout = 1'b1; #1; check("fetch_pc", {32'h0, BusMuxOut}, 64'h1); PCout = 1'b0;
        MDRout = 1'b1; #1; check("fetch_mdr", {32'h0, BusMuxOut}, 64'h54C6_0000);
        IRin = 1'b1; tick();
        check("fetch_ir", {32'h0, dut.ir}, 64'h54C6_0000);

        r_out[2] = 1'b1; Yin = 1'b1; tick();
        r_out[3] = 1'b1; ops = m(7); Zin = 1'b1; tick();
        Zlowout = 1'b1; r_in[1] = 1'b1; tick();
        check_reg("and_r1", 1, 32'h10);

        r_out[1] = 1'b1; r_in[1] = 1'b1; tick();
        check_reg("self_load_r1", 1, 32'h10);
        r_out[1] = 1'b1; r_out[2] = 1'b1; #1;
        check("bus_prio_r1_r2", {32'h0, BusMuxOut}, 64'h10); idle();
        r_out[3] = 1'b1; MDRout = 1'b1; #1;
        check("bus_prio_r3_mdr", {32'h0, BusMuxOut}, 64'h14); idle();

        Zlowout = 1'b1; Zin = 1'b1; #1;
        check("z_same_cycle_old", {32'h0, BusMuxOut}, 64'h10);
        tick();
        read_z(zv); check("z_same_cycle_new", zv, 64'h11);

        r_out[2] = 1'b1; HIin = 1'b1; tick();
        r_out[3] = 1'b1; LOin = 1'b1; tick();
        HIout = 1'b1; LOout = 1'b1; #1;
        check("hi_over_lo", {32'h0, BusMuxOut}, 64'h12); idle();
        LOout = 1'b1; #1;
        check("lo_value", {32'h0, BusMuxOut}, 64'h14); idle();

        tbl.push_back('{"add_wrap",  m(0),        32'h5,         32'hFFFF_FFFF, 64'h4});
        tbl.push_back('{"sub",       m(1),        32'h3,         32'h5,         64'hFFFF_FFFE});
        tbl.push_back('{"shr",       m(2),        32'h8000_0001, 32'h1,         64'h4000_0000});
        tbl.push_back('{"shra",      m(3),        32'h8000_0001, 32'h1,         64'hC000_0000});
        tbl.push_back('{"shl",       m(4),        32'h8000_0001, 32'h1,         64'h2});
        tbl.push_back('{"ror",       m(5),        32'h8000_0001, 32'h1,         64'hC000_0000});
        tbl.push_back('{"rol",       m(6),        32'h8000_0001, 32'h1,         64'h3});
        tbl.push_back('{"and",       m(7),        32'h12,        32'h14,        64'h10});
        tbl.push_back('{"or",        m(8),        32'h12,        32'h14,        64'h16});
        tbl.push_back('{"mul_neg",   m(9),        32'h7,         32'hFFFF_FFFD, 64'hFFFF_FFFF_FFFF_FFEB});
        tbl.push_back('{"div_neg",   m(10),       32'hFFFF_FFF9, 32'h2,         64'hFFFF_FFFF_FFFF_FFFD});
        tbl.push_back('{"div_zero",  m(10),       32'hFFFF_FFF9, 32'h0,         64'hFFFF_FFF9_FFFF_FFFF});
        tbl.push_back('{"neg",       m(11),       32'h5,         32'h1,         64'hFFFF_FFFF});
        tbl.push_back('{"not",       m(12),       32'h5,         32'h0F0F_0F0F, 64'hF0F0_F0F0});
        tbl.push_back('{"inc_wrap",  13'h0,       32'h5,         32'hFFFF_FFFF, 64'h0});
        tbl.push_back('{"prio_add",  m(0) | m(1), 32'h5,         32'h3,         64'h8});
        tbl.push_back('{"prio_mul",  m(9) | m(12),32'h7,         32'hFFFF_FFFD, 64'hFFFF_FFFF_FFFF_FFEB});
        tbl.push_back('{"shl_b40",   m(4),        32'h1,         32'h21,        64'h2});
        foreach (tbl[i]) begin
            alu_run(tbl[i].sel, tbl[i].a, tbl[i].b, zv);
            check(tbl[i].name, zv, tbl[i].exp);
        end

        for (int n = 0; n < 40; n++) begin
            int k = $urandom_range(0, 13);
            sel = (k == 13) ? 13'h0 : m(k);
            if ($urandom_range(0, 3) == 0) sel = sel | m($urandom_range(0, 12));
            a = $urandom;
            b = ($urandom_range(0, 7) == 0) ? 32'h0 : $urandom;
            if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) b = 32'h3;
            alu_run(sel, a, b, zv);
            check($sformatf("rand%0d_sel%h", n, sel), zv, ref_alu(sel, a, b));
        end

        load_mdr(32'hA5A5_0001); MDRout = 1'b1; r_in[7] = 1'b1; IRin = 1'b1; tick();
        #2;
        Clear = 1'b0;
        #1;
        check_reg("clr_r7", 7, 32'h0);
        check_reg("clr_r2", 2, 32'h0);
        check("clr_ir", {32'h0, dut.ir}, 64'h0);
        HIout = 1'b1; #1; check("clr_hi", {32'h0, BusMuxOut}, 64'h0); HIout = 1'b0;
        MDRout = 1'b1; #1; check("clr_mdr", {32'h0, BusMuxOut}, 64'h0); MDRout = 1'b0;
        read_z(zv); check("clr_z", zv, 64'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/data_path.md
# data_path

Single-bus 32-bit CPU datapath: sixteen general registers, PC, IR, MAR, MDR, Y, 64-bit Z, HI and LO, all joined by one shared bus, with an ALU between Y/bus and Z. It sits under the future control unit, which will drive every enable and select line directly. This block has no sequencing of its own. Each register loads from the bus on a clock edge when its enable is high.

## Interface
Parameters: none (data width fixed at 32).

Ports, in positional order:
- Clock  in  1  rising-edge clock for all registers.
- Clear  in  1  reset; asynchronous, active-low.
- HIin, HIout, LOin, LOout  in  1 each  HI/LO load enables and bus-drive selects.
- PCin, PCout  in  1 each  PC load enable and bus-drive select.
- IRin  in  1  IR load enable.
- Zin  in  1  Z load enable; loads the 64-bit ALU result.
- Zhighout, Zlowout  in  1 each  drive Z[63:32] or Z[31:0] onto the bus.
- Yin  in  1  Y load enable.
- MARin  in  1  MAR load enable.
- MDRin, MDRout  in  1 each  MDR load enable and bus-drive select.
- Read  in  1  MDR input select: 1 = Mdatain, 0 = bus.
- Mdatain  in  32  memory read data.
- R0out..R15out  in  1 each  general-register bus-drive selects.
- R0in..R15in  in  1 each  general-register load enables.
- ADD, SUB, SHR, SHRA, SHL, ROR, ROL, AND, OR, MUL, DIV, NEG, NOT  in  1 each  ALU operation selects.
- BusMuxOut  out  32  current bus value. It is a trailing debug port and may be left unconnected.

## Operation
**Bus**
- The bus is combinational.
- Source priority: R0..R15 (lowest index first), then HI, LO, Zhigh, Zlow, PC, MDR.
- With no source selected, the bus is 0.

**MDR**
- Input = Read ? Mdatain : bus.
- Loads when MDRin is high.

**ALU**
- Inputs: A = Y, B = bus. The output is 64 bits and is captured into Z when Zin is high.
- If several operation lines are high, the first in port order wins.
- ADD/SUB: A±B, wrapping mod 2^32.
- AND/OR: bitwise.
- SHR: logical right shift of A by B[4:0].
- SHRA: arithmetic right shift of A by B[4:0].
- SHL: left shift of A by B[4:0].
- ROR/ROL: rotate A by B[4:0].
- NEG: −B (two's complement). NOT: ~B.
- MUL: signed A×B, full 64 bits. High word → Z[63:32], low word → Z[31:0].
- DIV: signed A/B. Quotient → Z[31:0], remainder → Z[63:32], remainder takes the sign of A.
- DIV with B=0: Z[31:0]=32'hFFFFFFFF, Z[63:32]=A.
- Every operation except MUL and DIV sets Z[63:32]=0.
- No operation line high: Z = B+1. This is the PC-increment path.

**Registers**
- All registers are 32-bit except Z. They are plain storage; R0 is not hardwired to zero.

## Timing
- Every register updates on the rising edge of Clock when its enable is high, otherwise it holds.
- Clear=0 asynchronously zeroes all registers: R0–R15, PC, IR, MAR, MDR, Y, Z, HI, LO.
- While Clear=0, BusMuxOut = 0 unless a selected source is nonzero. With all registers cleared, the only possible nonzero source is Mdatain through MDR after release.
- Bus and ALU are combinational within a cycle. Load-to-bus latency is one edge: a value loaded on edge N is visible on the bus after edge N.
- A register may drive the bus and load from it in the same cycle. It captures the old bus value with no combinational loop, e.g. R1out with R1in = no-op.
- Simultaneous Zin and Zlowout: Z captures the new ALU result, and the bus shows the old Z.

## Structure
- Shared package: word width, the ALU op enum (13 ops plus INC), and the bus-source encoding.
- Sub-module `alu`: purely combinational. Inputs are A, B and the op; output is a 64-bit result. The shifter, multiplier and divider live inside it.
- The top level holds the register file, special registers, bus encoder/mux and MDR mux.

## Test plan
- Register load via MDR:
  - Mdatain=0x12, Read=1, MDRin=1, one edge.
  - Then MDRout=1, R2in=1, one edge → R2=0x12.
  - Repeat to get R3=0x14 and R1=0x18.
- Fetch:
  - PC=0. Cycle with PCout, MARin, Zin (no op) → MAR=0, Z=1.
  - Cycle with Zlowout, PCin, Read, MDRin, Mdatain=0x54C60000 → PC=1, MDR=0x54C60000.
  - Cycle with MDRout, IRin → IR=0x54C60000.
- AND sequence:
  - R2out, Yin → Y=0x12.
  - R3out, AND, Zin → Z=0x10.
  - Zlowout, R1in → R1=0x00000010.
- Arithmetic:
  - Y=7, bus=−3 with MUL → Z=0xFFFFFFFF_FFFFFFEB.
  - Y=−7, bus=2 with DIV → Zlow=−3, Zhigh=−1.
  - Bus=0 with DIV → Zlow=0xFFFFFFFF.
- Shifts:
  - Y=0x80000001, bus=1: SHR → 0x40000000; SHRA → 0xC0000000; ROL → 0x00000003; ROR → 0xC0000000.
- Reset mid-operation: drop Clear while loaded registers hold nonzero values → all registers read 0 immediately, without waiting for a clock edge.
